// File: rtl/vga_grid_renderer.sv
// 640x480@60 playfield renderer: ROWS x COLS cell codes -> fixed 8-colour palette, white border, per-frame snapshot.
// Optional macro GRID_LINES_EN draws 404040 lines on the first pixel row/column of every cell.
module vga_grid_renderer #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int CODE_W    = 3,
    parameter int CELL_PX   = 20,
    parameter int X0        = 220,
    parameter int Y0        = 40,
    parameter int BORDER_PX = 2
) (
    input  logic                        iVGA_CLK,
    input  logic                        iRST_n,
    input  logic [COLS*ROWS*CODE_W-1:0] grid_data,
    output logic                        oBLANK_n,
    output logic                        oHS,
    output logic                        oVS,
    output logic [7:0]                  r_data,
    output logic [7:0]                  g_data,
    output logic [7:0]                  b_data,
    output logic                        oFrameStart
);

    localparam int FRAME_W = COLS * ROWS * CODE_W;
    localparam int FIDX_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int GX_HI   = X0 + COLS * CELL_PX;
    localparam int GY_HI   = Y0 + ROWS * CELL_PX;
    localparam int BX_LO   = X0 - BORDER_PX;
    localparam int BX_HI   = GX_HI + BORDER_PX;
    localparam int BY_LO   = Y0 - BORDER_PX;
    localparam int BY_HI   = GY_HI + BORDER_PX;

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] HS_BEG   = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] VS_BEG   = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;
    localparam logic [9:0] X0_V     = 10'(X0);
    localparam logic [9:0] Y0_V     = 10'(Y0);
    localparam logic [9:0] SUB_LAST = 10'(CELL_PX - 1);

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 24'h000000;
            3'd1:    palette = 24'h00FFFF;
            3'd2:    palette = 24'hFFFF00;
            3'd3:    palette = 24'hFF00FF;
            3'd4:    palette = 24'h00FF00;
            3'd5:    palette = 24'hFF0000;
            3'd6:    palette = 24'h0000FF;
            default: palette = 24'hFF8000;
        endcase
    endfunction

    // S0: raster counters plus running cell counters (no dividers)
    logic [9:0]         hc_q, hc_d, vc_q, vc_d;
    logic [9:0]         col_idx_q, col_idx_d, col_sub_q, col_sub_d;
    logic [9:0]         row_idx_q, row_idx_d, row_sub_q, row_sub_d;
    logic [FRAME_W-1:0] frame_q;
    logic               frame_start_q;
    logic               snap;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end

        col_idx_d = col_idx_q;
        col_sub_d = col_sub_q;
        if (hc_d == X0_V) begin
            col_idx_d = '0;
            col_sub_d = '0;
        end else if (col_sub_q == SUB_LAST) begin
            col_sub_d = '0;
            col_idx_d = col_idx_q + 10'd1;
        end else begin
            col_sub_d = col_sub_q + 10'd1;
        end

        row_idx_d = row_idx_q;
        row_sub_d = row_sub_q;
        if (hc_q == H_LAST) begin
            if (vc_d == Y0_V) begin
                row_idx_d = '0;
                row_sub_d = '0;
            end else if (row_sub_q == SUB_LAST) begin
                row_sub_d = '0;
                row_idx_d = row_idx_q + 10'd1;
            end else begin
                row_sub_d = row_sub_q + 10'd1;
            end
        end
    end

    assign snap = (hc_q == 10'd0) && (vc_q == V_VIS);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            col_idx_q     <= '0;
            col_sub_q     <= '0;
            row_idx_q     <= '0;
            row_sub_q     <= '0;
            frame_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            col_idx_q     <= col_idx_d;
            col_sub_q     <= col_sub_d;
            row_idx_q     <= row_idx_d;
            row_sub_q     <= row_sub_d;
            frame_start_q <= snap;
            if (snap) frame_q <= grid_data;
        end
    end

    // S1: region flags, sync decode, cell code fetch from the snapshot
    int                hc_int, vc_int, cell_idx;
    logic              vis_s0, hs_s0, vs_s0, grid_s0, border_s0;
    logic [FIDX_W-1:0] bit_base;
    logic [CODE_W-1:0] code_raw;
    logic [7:0]        code_ext;
    logic [2:0]        code_s0;

    always_comb begin
        hc_int    = {22'd0, hc_q};
        vc_int    = {22'd0, vc_q};
        vis_s0    = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs_s0     = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
        vs_s0     = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
        grid_s0   = (hc_int >= X0) && (hc_int < GX_HI) && (vc_int >= Y0) && (vc_int < GY_HI);
        border_s0 = !grid_s0 && (hc_int >= BX_LO) && (hc_int < BX_HI) &&
                    (vc_int >= BY_LO) && (vc_int < BY_HI);
        cell_idx  = {22'd0, row_idx_q} * COLS + {22'd0, col_idx_q};
        bit_base  = FIDX_W'(cell_idx * CODE_W);
        code_raw  = '0;
        if (grid_s0) code_raw = frame_q[bit_base +: CODE_W];
        code_ext  = '0;
        code_ext[CODE_W-1:0] = code_raw;
        code_s0   = code_ext[2:0];
    end

    logic       vis_q, hs1_q, vs1_q, grid_q, border_q;
    logic [2:0] code_q;
`ifdef GRID_LINES_EN
    logic       line_q;
`endif

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vis_q    <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            grid_q   <= 1'b0;
            border_q <= 1'b0;
            code_q   <= '0;
`ifdef GRID_LINES_EN
            line_q   <= 1'b0;
`endif
        end else begin
            vis_q    <= vis_s0;
            hs1_q    <= hs_s0;
            vs1_q    <= vs_s0;
            grid_q   <= grid_s0;
            border_q <= border_s0;
            code_q   <= code_s0;
`ifdef GRID_LINES_EN
            line_q   <= (col_sub_q == 10'd0) || (row_sub_q == 10'd0);
`endif
        end
    end

    // S2: colour priority blank > border > grid > background
    logic [23:0] rgb_d, rgb_q;
    logic        blank_n_q, hs2_q, vs2_q;

    always_comb begin
        if (!vis_q)        rgb_d = 24'h000000;
        else if (border_q) rgb_d = 24'hFFFFFF;
        else if (grid_q) begin
`ifdef GRID_LINES_EN
            rgb_d = line_q ? 24'h404040 : palette(code_q);
`else
            rgb_d = palette(code_q);
`endif
        end
        else               rgb_d = 24'h202020;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rgb_q     <= '0;
            blank_n_q <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
        end else begin
            rgb_q     <= rgb_d;
            blank_n_q <= vis_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
        end
    end

    assign oBLANK_n    = blank_n_q;
    assign oHS         = hs2_q;
    assign oVS         = vs2_q;
    assign r_data      = rgb_q[23:16];
    assign g_data      = rgb_q[15:8];
    assign b_data      = rgb_q[7:0];
    assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed bench for vga_grid_renderer: frame timing statistics, pixel probes, snapshot and reset behaviour.
module tb_vga_grid_renderer;

  localparam int FRAME = 420000;
`ifdef GRID_LINES_EN
  localparam bit LINES = 1'b1;
`else
  localparam bit LINES = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [599:0] grid_data = '0;
  logic         blank_n, hs, vs, frame_start;
  logic [7:0]   r_data, g_data, b_data;
  logic [23:0]  rgb;
  assign rgb = {r_data, g_data, b_data};

  vga_grid_renderer dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .grid_data   (grid_data),
    .oBLANK_n    (blank_n),
    .oHS         (hs),
    .oVS         (vs),
    .r_data      (r_data),
    .g_data      (g_data),
    .b_data      (b_data),
    .oFrameStart (frame_start)
  );

  // cycles since reset release; counters show pixel index cyc, outputs show cyc-2
  int cyc;
  int epoch = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cell(input int r, input int c, input logic [2:0] code);
    grid_data[(r*10+c)*3 +: 3] = code;
  endtask

  // scoreboard of expected pixels
  typedef struct {
    int          ep;
    int          f;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        blank_n;
  } pix_t;
  pix_t exp_q[$];

  task automatic add_pix(input int ep, input int f, input int x, input int y,
                         input logic [23:0] c, input logic b);
    pix_t e;
    e.ep = ep; e.f = f; e.x = x; e.y = y; e.rgb = c; e.blank_n = b;
    exp_q.push_back(e);
  endtask

  // frame-0 statistics
  int hs_low_cnt = 0, vs_low_cnt = 0, blank_hi_cnt = 0, fs_cnt = 0;
  int first_hs = -1, first_vs = -1, first_blank = -1, first_fs = -1;
  int p, pf, off, px, py;

  always @(negedge clk) begin
    if (rst_n) begin
      if (epoch == 0 && cyc <= FRAME + 1) begin
        if (frame_start) begin
          fs_cnt++;
          if (first_fs < 0) first_fs = cyc;
        end
        if (cyc >= 2) begin
          if (!hs) hs_low_cnt++;
          if (!vs) vs_low_cnt++;
          if (blank_n) blank_hi_cnt++;
        end
        if (!hs && first_hs < 0) first_hs = cyc;
        if (!vs && first_vs < 0) first_vs = cyc;
        if (blank_n && first_blank < 0) first_blank = cyc;
      end
      p = cyc - 2;
      if (p >= 0) begin
        pf  = p / FRAME;
        off = p % FRAME;
        px  = off % 800;
        py  = off / 800;
        foreach (exp_q[i]) begin
          if (exp_q[i].ep == epoch && exp_q[i].f == pf && exp_q[i].x == px && exp_q[i].y == py) begin
            check($sformatf("rgb e%0d f%0d (%0d,%0d)", epoch, pf, px, py), {8'd0, rgb}, {8'd0, exp_q[i].rgb});
            check($sformatf("blank_n e%0d f%0d (%0d,%0d)", epoch, pf, px, py), {31'd0, blank_n}, {31'd0, exp_q[i].blank_n});
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " hs"},    {31'd0, hs},          32'd1);
    check({tag, " vs"},    {31'd0, vs},          32'd1);
    check({tag, " blank"}, {31'd0, blank_n},     32'd0);
    check({tag, " rgb"},   {8'd0, rgb},          32'd0);
    check({tag, " fs"},    {31'd0, frame_start}, 32'd0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    // frame 0: frame register still zero
    add_pix(0, 0,   0,   0, 24'h202020, 1'b1);
    add_pix(0, 0, 220,  40, LINES ? 24'h404040 : 24'h000000, 1'b1);
    add_pix(0, 0, 218,  40, 24'hFFFFFF, 1'b1);
    add_pix(0, 0, 100, 100, 24'h202020, 1'b1);
    add_pix(0, 0, 700, 100, 24'h000000, 1'b0);
    add_pix(0, 0, 420, 100, 24'hFFFFFF, 1'b1);
    add_pix(0, 0, 422, 100, 24'h202020, 1'b1);
    add_pix(0, 0, 220,  39, 24'hFFFFFF, 1'b1);
    add_pix(0, 0, 220,  37, 24'h202020, 1'b1);
    add_pix(0, 0, 219, 440, 24'hFFFFFF, 1'b1);
    add_pix(0, 0, 639, 479, 24'h202020, 1'b1);
    add_pix(0, 0, 640, 479, 24'h000000, 1'b0);
    // frame 1: cell(0,0)=5 snapshotted
    add_pix(0, 1, 220,  40, LINES ? 24'h404040 : 24'hFF0000, 1'b1);
    add_pix(0, 1, 239,  59, 24'hFF0000, 1'b1);
    add_pix(0, 1, 240,  40, LINES ? 24'h404040 : 24'h000000, 1'b1);
    add_pix(0, 1, 240,  45, LINES ? 24'h404040 : 24'h000000, 1'b1);
    add_pix(0, 1, 419, 439, 24'h000000, 1'b1);
    // frame 2: cell(19,9)=7, cell(0,1)=1
    add_pix(0, 2, 419, 439, 24'hFF8000, 1'b1);
    add_pix(0, 2, 240,  45, LINES ? 24'h404040 : 24'h00FFFF, 1'b1);
    add_pix(0, 2, 241,  45, 24'h00FFFF, 1'b1);
    add_pix(0, 2, 239,  59, 24'hFF0000, 1'b1);
    // frame 3: cell(0,0)=2 written in the snapshot cycle
    add_pix(0, 3, 239,  59, 24'hFFFF00, 1'b1);
    add_pix(0, 3, 100, 100, 24'h202020, 1'b1);
    // after mid-frame reset: all palette[0] again
    add_pix(1, 0,   0,   0, 24'h202020, 1'b1);
    add_pix(1, 0, 220,  40, LINES ? 24'h404040 : 24'h000000, 1'b1);
    add_pix(1, 0, 239,  59, 24'h000000, 1'b1);
    add_pix(1, 0, 241,  45, 24'h000000, 1'b1);

    set_cell(0, 0, 3'd5);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset0");
    rst_n = 1'b1;

    wait_cyc(FRAME + 2);
    check("hs_low_cycles",   hs_low_cnt,   32'd50400);
    check("vs_low_cycles",   vs_low_cnt,   32'd1600);
    check("blank_hi_cycles", blank_hi_cnt, 32'd307200);
    check("frame_pulses",    fs_cnt,       32'd1);
    check("first_fs_cyc",    first_fs,     32'd384001);
    check("first_hs_cyc",    first_hs,     32'd658);
    check("first_vs_cyc",    first_vs,     32'd392002);
    check("first_blank_cyc", first_blank,  32'd2);

    wait_cyc(FRAME + 100*800);
    set_cell(19, 9, 3'd7);
    set_cell(0, 1, 3'd1);

    wait_cyc(2*FRAME + 480*800);
    set_cell(0, 0, 3'd2);

    wait_cyc(3*FRAME + 300*800 + 102);
    check("pre_reset_blank", {31'd0, blank_n}, 32'd1);
    check("pre_reset_rgb",   {8'd0, rgb},      32'h202020);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held_reset");
    epoch = 1;
    rst_n = 1'b1;

    wait_cyc(59*800 + 239 + 10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
